jk_seq_ctrl: RTL

Sequencing controller for a bank of WIDTH JK flip-flops built from our SR-to-JK cells. On a start command it latches an operation (clear, count up, count down, load) and a step count. For that many clock cycles it drives the bank's j/k inputs with the excitation that moves the bank's current state to the next state, then pulses done. It owns no state bits of its own: the counter value lives in the external JK bank, which feeds back through q_in.

---
 rtl/jk_seq_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/jk_seq_ctrl.sv
// Sequencing controller for an external bank of JK flip-flops: it drives j/k with the
// excitation that moves the bank from its live value q_in_i to nxt(q_in_i) for a set number of cycles.
module jk_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SW    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [SW-1:0]    steps_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] q_in_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpUp    = 2'b01;
    localparam logic [1:0] OpDown  = 2'b10;
    localparam logic [1:0] OpLoad  = 2'b11;

    localparam logic [WIDTH-1:0] One   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]    StepOne = {{(SW-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [SW-1:0]    remaining_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] load_val_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            op_q        <= OpClear;
            limit_q     <= '0;
            load_val_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q        <= op_i;
                        limit_q     <= limit_i;
                        load_val_q  <= load_val_i;
                        remaining_q <= steps_i;
                        if (steps_i != '0) begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    remaining_q <= remaining_q - StepOne;
                    if (remaining_q == StepOne) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range bank values fold back into [0, limit] so +1/-1 never wrap the word.
    always_comb begin
        nxt = '0;
        unique case (op_q)
            OpClear: nxt = '0;
            OpUp:    nxt = (q_in_i >= limit_q) ? '0 : q_in_i + One;
            OpDown:  nxt = ((q_in_i == '0) || (q_in_i > limit_q)) ? limit_q : q_in_i - One;
            OpLoad:  nxt = load_val_q;
            default: nxt = '0;
        endcase
    end

    always_comb begin
        j_o = '0;
        k_o = '0;
        if (state_q == StRun) begin
            j_o = nxt & ~q_in_i;
            k_o = ~nxt & q_in_i;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
